// File: rtl/rf_pkg.sv
// Shared definitions for the RF control path: instruction encoding, SPI frame
// geometry, and the register addresses the control FSM polls.
package rf_pkg;

  localparam int unsigned FRAME_W   = 24;
  localparam int unsigned SHORT_LEN = 16;
  localparam int unsigned LONG_LEN  = 24;
  localparam int unsigned BCNT_W    = 5;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 8;

  localparam logic [5:0]        INTSTAT = 6'h31;
  localparam logic [ADDR_W-1:0] RXFIFO  = 10'h200;

  typedef enum logic [1:0] {
    SHORT_RD = 2'b00,
    SHORT_WR = 2'b01,
    LONG_RD  = 2'b10,
    LONG_WR  = 2'b11
  } rf_inst_e;

  typedef struct packed {
    rf_inst_e            inst;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } rf_req_t;

  function automatic logic is_long_op(input rf_inst_e inst);
    return (inst == LONG_RD) || (inst == LONG_WR);
  endfunction

  function automatic logic is_write_op(input rf_inst_e inst);
    return (inst == SHORT_WR) || (inst == LONG_WR);
  endfunction

  // Left-aligned frame; short frames leave the low byte zero so MOSI idles low afterwards.
  function automatic logic [FRAME_W-1:0] build_frame(input rf_req_t req);
    logic              wr;
    logic [DATA_W-1:0] d;
    wr = is_write_op(req.inst);
    d  = wr ? req.data : '0;
    if (is_long_op(req.inst)) begin
      return {1'b1, req.addr, wr, 4'b0000, d};
    end
    return {1'b0, req.addr[5:0], wr, d, 8'h00};
  endfunction

endpackage

// File: rtl/rf_spi_clk_gen.sv
// Phase timer for the SPI engine: ticks every CLK_DIV clk while enabled and
// decodes the tick into SCLK rise/fall enables from the current SCLK level.
module rf_spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic sclk_i,
  output logic tick_c_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_c;

  assign tick_c   = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign tick_c_o = tick_c;
  assign rise_c_o = tick_c && !sclk_i;
  assign fall_c_o = tick_c && sclk_i;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en_i || tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_spi_responder.sv
// Register-access engine between the RF control FSM and the 802.15.4 transceiver:
// one request per accepted cs_in, serialised as an SPI mode-0 frame.
module rf_spi_responder
  import rf_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_in,
  input  logic [1:0]        inst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                long_q, long_d;
  logic                wr_q, wr_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;

  logic                tick_c, rise_c, fall_c;
  logic [BCNT_W-1:0]   n_bits_c;
  rf_req_t             req_c;

  assign req_c    = '{inst: rf_inst_e'(inst), addr: addr, data: data_in};
  assign n_bits_c = long_q ? BCNT_W'(LONG_LEN) : BCNT_W'(SHORT_LEN);

  rf_spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q != IDLE),
    .sclk_i   (sclk_q),
    .tick_c_o (tick_c),
    .rise_c_o (rise_c),
    .fall_c_o (fall_c)
  );

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    rx_d       = rx_q;
    bcnt_d     = bcnt_q;
    long_d     = long_q;
    wr_d       = wr_q;
    ready_d    = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        if (ready_q && cs_in) begin
          ready_d = 1'b0;
          cs_n_d  = 1'b0;
          sr_d    = build_frame(req_c);
          long_d  = is_long_op(req_c.inst);
          wr_d    = is_write_op(req_c.inst);
          bcnt_d  = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (rise_c) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATA_W-2:0], spi_miso};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // bcnt counts completed falling edges; the rise after the last low phase ends the frame.
        if (fall_c) begin
          sclk_d = 1'b0;
          sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
          bcnt_d = bcnt_q + BCNT_W'(1);
        end else if (rise_c) begin
          if (bcnt_q == n_bits_c) begin
            state_d = HOLD;
            if (!wr_q) begin
              rd_data_d  = rx_q;
              rd_valid_d = 1'b1;
            end
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[DATA_W-2:0], spi_miso};
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          cs_n_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      rx_q       <= '0;
      bcnt_q     <= '0;
      long_q     <= 1'b0;
      wr_q       <= 1'b0;
      ready_q    <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      rx_q       <= rx_d;
      bcnt_q     <= bcnt_d;
      long_q     <= long_d;
      wr_q       <= wr_d;
      ready_q    <= ready_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
    end
  end

  assign ready    = ready_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = sr_q[FRAME_W-1];

endmodule

// File: tb/tb_rf_spi_responder.sv
// Bench for rf_spi_responder: a transceiver-side SPI model captures MOSI frames and
// returns MISO bytes; expected frames and read bytes are queued at request time.
module tb_rf_spi_responder;

  localparam int unsigned CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_in = 1'b0;
  logic [1:0] inst = 2'b00;
  logic [9:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  always #5 clk = ~clk;

  rf_spi_responder #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs_in    (cs_in),
    .inst     (inst),
    .addr     (addr),
    .data_in  (data_in),
    .ready    (ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  typedef struct {
    int          len;
    logic [23:0] bits;
    bit          abort;
  } exp_frame_t;

  exp_frame_t exp_fq[$];
  logic [7:0] exp_rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int frames_done = 0;
  int rd_seen = 0;

  // Transceiver model: counts SCLK rises, captures MOSI, drives the response byte MSB first.
  int          bitidx = 0;
  logic        long_f = 1'b0;
  logic [23:0] obs_bits = '0;
  int          low_cnt = 0;
  logic [7:0]  resp_byte = '0;
  int          data_start;

  assign data_start = long_f ? 16 : 8;
  assign spi_miso = (bitidx >= data_start && bitidx < data_start + 8) ?
                    resp_byte[7 - (bitidx - data_start)] : 1'b0;

  always @(negedge spi_cs_n) begin
    bitidx   = 0;
    obs_bits = '0;
    long_f   = 1'b0;
  end

  always @(posedge spi_sclk) begin
    if (bitidx == 0) long_f = spi_mosi;
    obs_bits = {obs_bits[22:0], spi_mosi};
    bitidx++;
  end

  always @(negedge clk) begin
    if (spi_cs_n === 1'b0) low_cnt++;
  end

  always @(posedge spi_cs_n) begin : frame_mon
    exp_frame_t e;
    if (exp_fq.size() == 0) begin
      if (!rst) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_frame: got %0d bits 0x%06h, none expected", bitidx, obs_bits);
      end
    end else begin
      e = exp_fq.pop_front();
      n_cmp++;
      if (e.abort) begin
        if (bitidx !== 10 || rst !== 1'b1) begin
          n_bad++;
          $display("FAIL abort_frame: bits=%0d rst=%b, required bits=10 rst=1", bitidx, rst);
        end
      end else if (bitidx !== e.len || obs_bits !== e.bits ||
                   low_cnt !== e.len * 2 * CLK_DIV + 2 * CLK_DIV) begin
        n_bad++;
        $display("FAIL frame: got len=%0d bits=0x%06h cs_low=%0d, required len=%0d bits=0x%06h cs_low=%0d",
                 bitidx, obs_bits, low_cnt, e.len, e.bits, e.len * 2 * CLK_DIV + 2 * CLK_DIV);
      end
      frames_done++;
    end
    low_cnt = 0;
  end

  always @(negedge clk) begin : rd_mon
    logic [7:0] ev;
    if (rd_valid === 1'b1) begin
      n_cmp++;
      rd_seen++;
      if (exp_rq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rd_valid: rd_data=0x%02h, no read pending", rd_data);
      end else begin
        ev = exp_rq.pop_front();
        if (rd_data !== ev) begin
          n_bad++;
          $display("FAIL rd_data: got 0x%02h, required 0x%02h", rd_data, ev);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_ready_timeout: ready=%b, required 1", name, ready);
    end
  endtask

  task automatic do_req(input logic [1:0] i, input logic [9:0] a, input logic [7:0] d,
                        input logic [7:0] resp, input logic [23:0] exp_bits,
                        input int exp_lat, input string name);
    exp_frame_t e;
    int lat;
    wait_ready(name);
    e.len   = i[1] ? 24 : 16;
    e.bits  = exp_bits;
    e.abort = 1'b0;
    exp_fq.push_back(e);
    if (!i[0]) exp_rq.push_back(resp);
    resp_byte = resp;
    cs_in = 1'b1; inst = i; addr = a; data_in = d;
    @(posedge clk); #1;
    cs_in = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_accept: ready=%b, required 0", name, ready);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ready !== 1'b1 && lat < 2000);
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready, rd_data, rd_valid, spi_cs_n, spi_sclk, spi_mosi} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: ready=%b rd_data=%02h rd_valid=%b cs_n=%b sclk=%b mosi=%b, required 1 00 0 1 0 0",
               ready, rd_data, rd_valid, spi_cs_n, spi_sclk, spi_mosi);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || spi_cs_n !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_after_reset: ready=%b cs_n=%b, required 1 1", ready, spi_cs_n);
    end
  endtask

  task automatic test_short_wr();
    do_req(2'b01, 10'h018, 8'h55, 8'h00, 24'h003155, 141, "short_wr");
    n_cmp++;
    if (rd_data !== 8'h00) begin
      n_bad++;
      $display("FAIL short_wr_rd_data: got 0x%02h, required 0x00", rd_data);
    end
  endtask

  task automatic test_short_rd();
    int seen0;
    seen0 = rd_seen;
    do_req(2'b00, 10'h031, 8'hFF, 8'hA5, 24'h006200, 141, "short_rd");
    n_cmp++;
    if (rd_seen - seen0 !== 1 || rd_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL short_rd_result: pulses=%0d rd_data=0x%02h, required 1 0xA5", rd_seen - seen0, rd_data);
    end
  endtask

  task automatic test_long_wr();
    do_req(2'b11, 10'h222, 8'h3C, 8'h00, 24'hC4503C, 205, "long_wr");
    n_cmp++;
    if (rd_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL long_wr_keeps_rd_data: got 0x%02h, required 0xA5", rd_data);
    end
  endtask

  task automatic test_long_rd_loop();
    int seen0;
    logic [9:0] a;
    seen0 = rd_seen;
    for (int k = 0; k < 8; k++) begin
      a = 10'h200 + 10'(k);
      do_req(2'b10, a, 8'h00, 8'(k), {1'b1, a, 13'b0}, 205, "long_rd");
    end
    n_cmp++;
    if (rd_seen - seen0 !== 8 || rd_data !== 8'h07) begin
      n_bad++;
      $display("FAIL long_rd_loop: pulses=%0d rd_data=0x%02h, required 8 0x07", rd_seen - seen0, rd_data);
    end
  endtask

  task automatic test_cs_held();
    exp_frame_t e;
    int f0;
    e.len = 16; e.bits = 24'h000B81; e.abort = 1'b0;
    wait_ready("cs_held");
    f0 = frames_done;
    exp_fq.push_back(e);
    exp_fq.push_back(e);
    cs_in = 1'b1; inst = 2'b01; addr = 10'h005; data_in = 8'h81;
    @(posedge clk); #1;
    cs_in = 1'b0;
    repeat (60) @(negedge clk);
    cs_in = 1'b1;
    @(negedge clk);
    cs_in = 1'b0;
    n_cmp++;
    if (ready !== 1'b0 || spi_cs_n !== 1'b0) begin
      n_bad++;
      $display("FAIL cs_held_mid_shift: ready=%b cs_n=%b, required 0 0", ready, spi_cs_n);
    end
    repeat (40) @(negedge clk);
    cs_in = 1'b1;
    wait_ready("cs_held_first");
    n_cmp++;
    if (frames_done - f0 !== 1) begin
      n_bad++;
      $display("FAIL cs_held_first_only: frames=%0d, required 1", frames_done - f0);
    end
    @(posedge clk); #1;
    cs_in = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL cs_held_reaccept: ready=%b, required 0", ready);
    end
    wait_ready("cs_held_second");
    repeat (5) @(negedge clk);
    n_cmp++;
    if (frames_done - f0 !== 2 || exp_fq.size() !== 0) begin
      n_bad++;
      $display("FAIL cs_held_count: frames=%0d pending=%0d, required 2 0", frames_done - f0, exp_fq.size());
    end
  endtask

  task automatic test_reset_abort();
    exp_frame_t e;
    int w;
    e.len = 24; e.bits = 24'h0; e.abort = 1'b1;
    wait_ready("abort");
    exp_fq.push_back(e);
    resp_byte = 8'hEE;
    cs_in = 1'b1; inst = 2'b10; addr = 10'h200; data_in = 8'h00;
    @(posedge clk); #1;
    cs_in = 1'b0;
    w = 0;
    while (bitidx != 10 && w < 500) begin
      @(negedge clk);
      w++;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({spi_cs_n, spi_sclk, ready, rd_valid, rd_data} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL abort_outputs: cs_n=%b sclk=%b ready=%b rd_valid=%b rd_data=%02h, required 1 0 1 0 00",
               spi_cs_n, spi_sclk, ready, rd_valid, rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    do_req(2'b00, 10'h031, 8'h00, 8'h5A, 24'h006200, 141, "after_abort");
    n_cmp++;
    if (rd_data !== 8'h5A) begin
      n_bad++;
      $display("FAIL after_abort_rd_data: got 0x%02h, required 0x5A", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_short_wr();
    test_short_rd();
    test_long_wr();
    test_long_rd_loop();
    test_cs_held();
    test_reset_abort();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_fq.size() !== 0 || exp_rq.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: frames pending=%0d reads pending=%0d, required 0 0",
               exp_fq.size(), exp_rq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
